// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one doubleword request at a time, commits byte-masked
// stores at the acceptance edge and answers every request exactly LATENCY cycles later.
module dmem_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] dm_req_addr,
    input  logic [63:0] dm_req_wdata,
    input  logic [7:0]  dm_req_wmask,
    input  logic        dm_req_wen,
    input  logic        dm_req_valid,
    output logic        dm_req_ready,
    output logic [63:0] dm_resp_rdata,
    output logic        dm_resp_valid
);

    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [2:0] LAT_LOAD = (LATENCY < 1) ? 3'd1 :
                                      (LATENCY > 4) ? 3'd4 : 3'(LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    logic [63:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic [63:0]           rd_word;
    logic [63:0]           wr_word;
    logic                  accept;
    state_e                state;

    logic [2:0]  cnt_q, cnt_d;
    logic        resp_valid_q, resp_valid_d;
    logic [63:0] rdata_q, rdata_d;
    logic [63:0] stage_q, stage_d;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{dm_req_addr[63:ADDR_WIDTH+3], dm_req_addr[2:0]};

    // Upper address bits are dropped, so the array aliases every 2^ADDR_WIDTH doublewords.
    assign idx     = dm_req_addr[ADDR_WIDTH+2:3];
    assign rd_word = mem[idx];

    always_comb begin
        wr_word = rd_word;
        for (int i = 0; i < 8; i++) begin
            if (dm_req_wmask[i]) begin
                wr_word[8*i +: 8] = dm_req_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        if (cnt_q == 3'd0) begin
            state = IDLE;
        end else if (cnt_q == 3'd1) begin
            state = RESP;
        end else begin
            state = WAIT;
        end
    end

    // Ready depends only on state and reset, never on the request itself.
    assign dm_req_ready = !rst && (state != WAIT);
    assign accept       = dm_req_valid && dm_req_ready;

    always_comb begin
        cnt_d   = cnt_q;
        stage_d = stage_q;
        rdata_d = rdata_q;
        case (state)
            IDLE:    cnt_d = 3'd0;
            WAIT:    cnt_d = cnt_q - 3'd1;
            RESP:    cnt_d = 3'd0;
            default: cnt_d = 3'd0;
        endcase
        if (accept) begin
            cnt_d   = LAT_LOAD;
            stage_d = rd_word;
        end
        resp_valid_d = (cnt_d == 3'd1);
        // The visible read data only moves when a response is about to be presented.
        if (resp_valid_d) begin
            rdata_d = accept ? rd_word : stage_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= 3'd0;
            resp_valid_q <= 1'b0;
            rdata_q      <= 64'h0;
        end else begin
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && dm_req_wen) begin
            mem[idx] <= wr_word;
        end
        stage_q <= stage_d;
    end

    assign dm_resp_valid = resp_valid_q;
    assign dm_resp_rdata = rdata_q;

endmodule
